// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared encodings for the pipeline stall/flush sequencer
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2,
        ST_ERROR = 2'd3
    } ctrl_state_t;

    // addi x0, x0, 0 loaded into IF/ID when it is flushed
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - saturating event counter with synchronous clear
module pipeline_stall_controller_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage RV32I pipeline
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             timeout_err,
    output logic [1:0]       ctrl_state
);

    ctrl_state_t       state, state_nxt;
    logic              discard, discard_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              flush_inc;
    logic              dstall;
    logic              wd_hit;

    assign dstall = dmem_req && !dmem_ready;
    assign wd_hit = (WAIT_LIMIT != 0) && (wait_cnt == WAIT_W'(WAIT_LIMIT));

    always_comb begin
        pc_write      = 1'b1;
        pc_redirect   = 1'b0;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        discard_nxt   = discard;
        wait_cnt_nxt  = wait_cnt;
        flush_inc     = 1'b0;

        // Inputs are masked while in reset so the pipeline sees a plain RUN cycle
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (dstall) begin
                        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                        mem_wb_bubble = 1'b1;
                        state_nxt     = ST_DWAIT;
                        wait_cnt_nxt  = '0;
                    end else if (branch_taken) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        discard_nxt = !imem_ready;
                        if (!imem_ready) begin
                            state_nxt    = ST_IWAIT;
                            wait_cnt_nxt = '0;
                        end
                    end else if (!imem_ready) begin
                        pc_write     = 1'b0;
                        if_id_flush  = 1'b1;
                        state_nxt    = ST_IWAIT;
                        wait_cnt_nxt = '0;
                    end else if (discard) begin
                        // wrong-path fetch still owed from before a data wait
                        if_id_flush = 1'b1;
                        discard_nxt = 1'b0;
                    end else if (load_use_hazard) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end

                ST_DWAIT: begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                    if (!dmem_ready) begin
                        mem_wb_bubble = 1'b1;
                        if (wd_hit) state_nxt = ST_ERROR;
                        else        wait_cnt_nxt = wait_cnt + 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end

                ST_IWAIT: begin
                    if (dstall) begin
                        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                        mem_wb_bubble = 1'b1;
                        state_nxt     = ST_DWAIT;
                        wait_cnt_nxt  = '0;
                    end else if (branch_taken) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        if (imem_ready) begin
                            discard_nxt = 1'b0;
                            state_nxt   = ST_RUN;
                        end else begin
                            discard_nxt = 1'b1;
                            if (wd_hit) state_nxt = ST_ERROR;
                            else        wait_cnt_nxt = wait_cnt + 1'b1;
                        end
                    end else if (!imem_ready) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        if (load_use_hazard) begin
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        if (wd_hit) state_nxt = ST_ERROR;
                        else        wait_cnt_nxt = wait_cnt + 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                        if (discard) begin
                            if_id_flush = 1'b1;
                            discard_nxt = 1'b0;
                        end else if (load_use_hazard) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end

                default: begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            discard     <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            discard  <= discard_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ST_ERROR) timeout_err <= 1'b1;
        end
    end

    assign ctrl_state = state;

    pipeline_stall_controller_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (!rst && (state != ST_ERROR) && !pc_write),
        .count (stall_count)
    );

    pipeline_stall_controller_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    localparam int CNT_W = 4;

    // {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble}
    localparam logic [7:0] NORM   = 8'b1010_1010;
    localparam logic [7:0] LU     = 8'b0000_1110;
    localparam logic [7:0] BR     = 8'b1111_1110;
    localparam logic [7:0] FREEZE = 8'b0000_0001;
    localparam logic [7:0] DREL   = 8'b0000_0000;
    localparam logic [7:0] IW     = 8'b0011_1010;
    localparam logic [7:0] DISC   = 8'b1011_1010;
    localparam logic [7:0] ERR    = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use_hazard = 1'b0;
    logic branch_taken = 1'b0;
    logic imem_ready = 1'b1;
    logic dmem_req = 1'b0;
    logic dmem_ready = 1'b0;
    logic pc_write, pc_redirect, if_id_write, if_id_flush;
    logic id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic timeout_err;
    logic [1:0] ctrl_state;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    pipeline_stall_controller #(.CNT_W(CNT_W), .WAIT_LIMIT(4), .WAIT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .pc_redirect     (pc_redirect),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_count     (stall_count),
        .flush_count     (flush_count),
        .timeout_err     (timeout_err),
        .ctrl_state      (ctrl_state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the response expected in that cycle
    task automatic step(input string nm, input logic r, input logic lu, input logic br,
                        input logic imr, input logic dreq, input logic drdy,
                        input logic [7:0] ctl, input logic [1:0] st, input logic terr,
                        input logic [3:0] fc, input logic [3:0] sc);
        @(posedge clk);
        #1;
        rst             = r;
        load_use_hazard = lu;
        branch_taken    = br;
        imem_ready      = imr;
        dmem_req        = dreq;
        dmem_ready      = drdy;
        exp_q.push_back({st, terr, fc, sc, ctl});
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [18:0] e;
            logic [18:0] a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {ctrl_state, timeout_err, flush_count, stall_count,
                 pc_write, pc_redirect, if_id_write, if_id_flush,
                 id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st/terr/fc/sc/ctl=%h required %h", n, a, e);
            end
        end
    end

    initial begin
        logic [3:0] s;
        repeat (2) @(posedge clk);
        // reset masks all inputs
        step("reset_masked", 1, 1, 1, 0, 1, 0, NORM, 2'd0, 0, 4'd0, 4'd0);
        step("idle",         0, 0, 0, 1, 0, 0, NORM, 2'd0, 0, 4'd0, 4'd0);
        step("load_use",     0, 1, 0, 1, 0, 0, LU,   2'd0, 0, 4'd0, 4'd0);
        step("lu_release",   0, 0, 0, 1, 0, 0, NORM, 2'd0, 0, 4'd0, 4'd1);
        step("branch_lu",    0, 1, 1, 1, 0, 0, BR,   2'd0, 0, 4'd0, 4'd1);
        step("post_branch",  0, 0, 0, 1, 0, 0, NORM, 2'd0, 0, 4'd1, 4'd1);
        step("dwait_start",  0, 0, 0, 1, 1, 0, FREEZE, 2'd0, 0, 4'd1, 4'd1);
        step("dwait_1",      0, 0, 0, 1, 1, 0, FREEZE, 2'd1, 0, 4'd1, 4'd2);
        step("dwait_2",      0, 0, 0, 1, 1, 0, FREEZE, 2'd1, 0, 4'd1, 4'd3);
        step("dwait_ready",  0, 0, 0, 1, 1, 1, DREL,   2'd1, 0, 4'd1, 4'd4);
        step("dwait_done",   0, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd1, 4'd5);
        step("mid_reset",    1, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd1, 4'd5);
        step("after_reset",  0, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd0, 4'd0);
        // wrong-path discard: branch lands while a fetch is outstanding
        step("imiss",        0, 0, 0, 0, 0, 0, IW,     2'd0, 0, 4'd0, 4'd0);
        step("iwait_branch", 0, 0, 1, 0, 0, 0, BR,     2'd2, 0, 4'd0, 4'd1);
        step("iwait_hold",   0, 0, 0, 0, 0, 0, IW,     2'd2, 0, 4'd1, 4'd1);
        step("iwait_drop",   0, 0, 0, 1, 0, 0, DISC,   2'd2, 0, 4'd1, 4'd2);
        step("iwait_capture",0, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd1, 4'd2);
        step("run_br_imiss", 0, 0, 1, 0, 0, 0, BR,     2'd0, 0, 4'd1, 4'd2);
        step("run_br_drop",  0, 0, 0, 1, 0, 0, DISC,   2'd2, 0, 4'd2, 4'd2);
        step("run_br_done",  0, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd2, 4'd2);
        // watchdog: five DWAIT cycles then ERROR
        step("wd_start",     0, 0, 0, 1, 1, 0, FREEZE, 2'd0, 0, 4'd2, 4'd2);
        for (int i = 0; i < 5; i++) begin
            s = 4'(3 + i);
            step("wd_wait",  0, 0, 0, 1, 1, 0, FREEZE, 2'd1, 0, 4'd2, s);
        end
        step("wd_error",     0, 0, 0, 1, 1, 0, ERR,    2'd3, 1, 4'd2, 4'd8);
        step("error_sticky", 0, 1, 1, 1, 1, 1, ERR,    2'd3, 1, 4'd2, 4'd8);
        step("error_reset",  1, 0, 0, 1, 0, 0, NORM,   2'd3, 1, 4'd2, 4'd8);
        step("error_clear",  0, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd0, 4'd0);
        // saturation of the 4-bit stall counter
        for (int i = 0; i < 20; i++) begin
            s = (i > 15) ? 4'd15 : 4'(i);
            step("sat_lu",   0, 1, 0, 1, 0, 0, LU,     2'd0, 0, 4'd0, s);
        end
        step("sat_hold",     0, 0, 0, 1, 0, 0, NORM,   2'd0, 0, 4'd0, 4'd15);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Arbitrates four stall/flush sources into one consistent set of pipeline-register enables/flushes and PC control:
  - load-use hazard from the hazard detection unit
  - taken branch/jump resolved in EX
  - instruction-memory wait
  - data-memory wait
- Also tracks outstanding wrong-path fetches, watchdogs memory waits, and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of stall_count and flush_count
WAIT_LIMIT, 255, consecutive wait cycles before timeout; 0 disables the watchdog
WAIT_W, 8, width of the internal wait counter; must satisfy WAIT_LIMIT < 2^WAIT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
load_use_hazard  input  1  stall request from hazard detection unit (ID depends on load in EX)
branch_taken  input  1  EX stage resolved a taken branch/jump this cycle
imem_ready  input  1  instruction fetch data valid this cycle
dmem_req  input  1  MEM stage instruction accesses data memory
dmem_ready  input  1  data memory access completes this cycle
pc_write  output  1  PC register enable
pc_redirect  output  1  PC mux selects branch target
if_id_write  output  1  IF/ID enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_write  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX loads bubble (controls zeroed)
ex_mem_write  output  1  EX/MEM enable
mem_wb_bubble  output  1  MEM/WB loads bubble
stall_count  output  CNT_W  cycles with pc_write=0, saturating
flush_count  output  CNT_W  branch redirects taken, saturating
timeout_err  output  1  sticky watchdog error
ctrl_state  output  2  current FSM state, for debug

Behaviour:
- Decoded outputs are combinational from state, discard flag and inputs; counters and FSM are registered.
- Default (RUN, no events): all writes=1, flushes/bubble/redirect=0.
- State encoding: RUN=0, DWAIT=1, IWAIT=2, ERROR=3.
- RUN priority, highest first:
  1. dmem_req & !dmem_ready: freeze the pipeline.
     - pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble=1.
     - Next state DWAIT.
  2. branch_taken: pc_redirect=1, if_id_flush=1, id_ex_flush=1; load_use_hazard ignored.
     - flush_count += 1.
     - If !imem_ready the same cycle, set discard=1 and go to IWAIT.
  3. !imem_ready: pc_write=0, if_id_flush=1. Next state IWAIT.
  4. load_use_hazard: pc_write=0, if_id_write=0, id_ex_flush=1.
- DWAIT:
  - Freeze as in RUN rule 1 while !dmem_ready.
  - On dmem_ready: MEM/WB captures normally (mem_wb_bubble=0); other stages still hold that cycle. Next state RUN.
  - A branch in EX is held frozen and re-evaluated in RUN.
- IWAIT:
  - pc_write=0, if_id_flush=1 while !imem_ready.
  - branch_taken in IWAIT: pc_redirect=1, pc_write=1, id_ex_flush=1, discard=1, flush_count += 1.
  - load_use_hazard still applies to ID/EX (id_ex_flush=1, if_id_write=0).
  - On imem_ready:
    - discard=0 → IF/ID captures the fetch; next state RUN.
    - discard=1 → if_id_flush=1 (wrong-path instruction dropped), discard cleared, PC advances to re-fetch the target; next state RUN.
  - A dmem stall in IWAIT takes priority: freeze and go to DWAIT.
  - discard is preserved across DWAIT.
- Watchdog:
  - wait_cnt resets to 0 on entry to DWAIT/IWAIT and increments each cycle there.
  - When wait_cnt == WAIT_LIMIT and WAIT_LIMIT != 0: go to ERROR.
  - ERROR: all writes 0, all flushes 0, timeout_err=1. Exit only by rst.
- Counters:
  - stall_count increments each cycle pc_write=0, except in ERROR.
  - Both counters saturate at 2^CNT_W-1.
- Reset (synchronous, rst high at rising clk):
  - state=RUN, discard=0, wait_cnt=0, counters=0, timeout_err=0.
  - During reset cycles the outputs reflect RUN with inputs masked: pc_write=1, all writes=1, flushes/bubble/redirect=0.
  - Reset mid-wait abandons the wait; no counter update that cycle.

Decomposition:
- Shared package/header:
  - state encodings RUN/DWAIT/IWAIT/ERROR
  - NOP instruction constant 32'h00000013, used by IF/ID flush logic elsewhere
- One natural sub-module: sat_counter (parameterised width, inc, clear). Instantiate it twice for the performance counters.

Test Plan:
- Load-use: load_use_hazard=1 one cycle in RUN → pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_count 0→1.
- Branch plus load-use in the same cycle → pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- dmem wait: dmem_req=1, dmem_ready low for 3 cycles, then high → ctrl_state goes 1 for 3 cycles then 0.
  - mem_wb_bubble=1 for those 3 cycles, 0 on the ready cycle.
  - stall_count=4.
- Wrong-path discard: imem_ready=0 then branch_taken in IWAIT, imem_ready high 2 cycles later → that returned fetch sees if_id_flush=1; next fetch captured; flush_count=1.
- Timeout with WAIT_LIMIT=4: dmem_ready held 0 → ctrl_state=3 after 5 cycles of waiting; timeout_err=1 and all writes 0 until rst; rst clears everything.
- Saturation with CNT_W=4: hold load_use 20 cycles → stall_count stops at 15.
